// File: rtl/mode_arbiter.sv
// mode_arbiter: picks which mode block drives the LCD and receives switch presses,
// blanking the display across mode changes until a frame boundary and forcing an
// alarm screen on alarm_hit.
// Ports:
//   clk, rst (async, active-low)
//   dip_sw      mode request (0001/0010/0100 -> mode 1/2/3, else mode 0)
//   sw_out      debounced switch levels
//   en_1hz      1 Hz enable pulse
//   alarm_hit   alarm-match pulse
//   index_char  LCD character position under write
//   data_mode0..3  characters from each mode block
//   data_char   character to the LCD driver
//   sw_evt0..3  per-mode switch-press pulses
//   mode        currently displayed mode
//   alarm_active   high while the alarm screen is forced
module mode_arbiter #(
    parameter int unsigned ALARM_SEC  = 10,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dip_sw,
    input  logic [3:0] sw_out,
    input  logic       en_1hz,
    input  logic       alarm_hit,
    input  logic [4:0] index_char,
    input  logic [7:0] data_mode0,
    input  logic [7:0] data_mode1,
    input  logic [7:0] data_mode2,
    input  logic [7:0] data_mode3,
    output logic [7:0] data_char,
    output logic [3:0] sw_evt0,
    output logic [3:0] sw_evt1,
    output logic [3:0] sw_evt2,
    output logic [3:0] sw_evt3,
    output logic [1:0] mode,
    output logic       alarm_active
);
    typedef enum logic [1:0] {RUN, SWITCH, ALARM} state_t;
    state_t          state, state_nx;
    logic [1:0]      mode_nx, target, target_nx, req;
    logic [7:0]      cnt, cnt_nx, cnt_inc;
    logic [3:0]      sw_q, rise;
    logic [4:0]      idx_q;
    logic [3:0][3:0] evt, evt_nx;
    logic            frame;

    assign req = dip_sw == 4'b0001 ? 2'd1 :
                 dip_sw == 4'b0010 ? 2'd2 :
                 dip_sw == 4'b0100 ? 2'd3 : 2'd0;
    assign rise    = sw_out & ~sw_q;
    assign frame   = index_char == 5'd0 && idx_q == 5'd31;
    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_nx  = state;
        mode_nx   = mode;
        target_nx = target;
        cnt_nx    = cnt;
        evt_nx    = '0;
        // alarm_hit wins over everything, including a same-cycle switch edge or alarm timeout
        if (alarm_hit) begin
            state_nx = ALARM;
            mode_nx  = 2'd0;
            cnt_nx   = 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (req != mode) begin
                        state_nx  = SWITCH;
                        target_nx = req;
                    end else
                        evt_nx[mode] = rise;
                end
                SWITCH: begin
                    // target tracks the request, but only the frame boundary ends the blanking
                    target_nx = req;
                    if (frame) begin
                        state_nx = RUN;
                        mode_nx  = target;
                    end
                end
                ALARM: begin
                    // a switch press only acknowledges the alarm and is not forwarded
                    if (|rise || (en_1hz && cnt_inc == 8'(ALARM_SEC))) begin
                        state_nx  = SWITCH;
                        target_nx = req;
                    end else if (en_1hz)
                        cnt_nx = cnt_inc;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            mode   <= 2'd0;
            target <= 2'd0;
            cnt    <= 8'd0;
            sw_q   <= 4'd0;
            idx_q  <= 5'd0;
            evt    <= '0;
        end else begin
            state  <= state_nx;
            mode   <= mode_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
            sw_q   <= sw_out;
            idx_q  <= index_char;
            evt    <= evt_nx;
        end
    end

    assign data_char = state == SWITCH ? BLANK_CHAR :
                       state == ALARM  ? data_mode0 :
                       mode == 2'd1    ? data_mode1 :
                       mode == 2'd2    ? data_mode2 :
                       mode == 2'd3    ? data_mode3 : data_mode0;
    assign alarm_active = state == ALARM;
    assign sw_evt0 = evt[0];
    assign sw_evt1 = evt[1];
    assign sw_evt2 = evt[2];
    assign sw_evt3 = evt[3];
endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 Parameter ALARM_SEC, default 10: en_1hz ticks the alarm display holds before auto-release, range 1..255.
REQ-002 Parameter BLANK_CHAR, default 8'h20: character driven to the LCD during a mode transition.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 dip_sw  in  4  mode request: 0001 selects mode 1, 0010 mode 2, 0100 mode 3, any other value mode 0.
REQ-006 sw_out  in  4  debounced push-switch levels, active-high.
REQ-007 en_1hz  in  1  one-cycle 1 Hz enable pulse.
REQ-008 alarm_hit  in  1  one-cycle alarm-match pulse.
REQ-009 index_char  in  5  LCD character position under write, 0..31.
REQ-010 data_mode0..data_mode3  in  8 each  character from each mode block for index_char.
REQ-011 data_char  out  8  character to the LCD driver.
REQ-012 sw_evt0..sw_evt3  out  4 each  one-cycle switch-press pulses, one vector per mode block.
REQ-013 mode  out  2  currently displayed mode.
REQ-014 alarm_active  out  1  high while the alarm display is forced.

Function
REQ-015 The block SHALL run a three-state FSM: RUN, SWITCH, ALARM.
REQ-016 Rising edges SHALL be detected per bit of sw_out against a one-cycle-delayed register; an edge at cycle N SHALL appear as a registered pulse at N+1.
REQ-017 In RUN, each detected edge SHALL pulse only the matching bit of sw_evt[mode]; the other three sw_evt vectors SHALL stay 0.
REQ-018 In RUN, data_char SHALL combinationally equal data_mode[mode].
REQ-019 In RUN, a decoded request differing from mode SHALL move the FSM to SWITCH on the next edge, latching the request as target.
REQ-020 In SWITCH, data_char SHALL be BLANK_CHAR and every sw_evt bit SHALL be 0.
REQ-021 SWITCH SHALL exit on a frame boundary: the first cycle where index_char is 0 and its registered previous value was 31; mode <= target, FSM -> RUN.
REQ-022 A request change during SWITCH SHALL update target without restarting the frame wait; if the request returns to mode, the exit still waits for the frame boundary.
REQ-023 alarm_hit in RUN or SWITCH SHALL enter ALARM on the next edge, clear the second counter to 0, and force mode to 0.
REQ-024 In ALARM, alarm_active SHALL be 1, data_char SHALL equal data_mode0, and every sw_evt bit SHALL be 0.
REQ-025 In ALARM, each en_1hz SHALL increment an 8-bit second counter; reaching ALARM_SEC SHALL exit to SWITCH with target = the current decoded request.
REQ-026 In ALARM, any rising edge on sw_out SHALL acknowledge the alarm, exit to SWITCH as in REQ-025, and not be forwarded.
REQ-027 alarm_hit during ALARM SHALL clear the second counter and keep the FSM in ALARM.
REQ-028 alarm_hit and a switch edge in the same cycle SHALL give priority to alarm_hit; the edge is dropped.
REQ-029 ALARM exit and a new alarm_hit in the same cycle SHALL stay in ALARM with the counter cleared.

Reset
REQ-030 While rst = 0: FSM = RUN, mode = 0, target = 0, second counter = 0, alarm_active = 0, all sw_evt = 0, edge and index history registers = 0.
REQ-031 On release, a dip_sw request other than mode 0 SHALL enter SWITCH on the first clock edge.
REQ-032 rst asserted mid-SWITCH or mid-ALARM SHALL abort at once to the REQ-030 state.

Verification
REQ-033 dip_sw = 0000, RUN, sw_out[2] rises -> sw_evt0 = 0100 for exactly one cycle, sw_evt1..3 = 0.
REQ-034 dip_sw 0000 -> 0010 mid-frame -> data_char = 8'h20 until index_char wraps 31 -> 0, then mode = 2 and data_char = data_mode2.
REQ-035 mode = 3, alarm_hit pulse -> alarm_active = 1, mode = 0; after 10 en_1hz pulses -> SWITCH, then mode = 3 at the next frame boundary.
REQ-036 ALARM, sw_out[0] rises after 3 s -> alarm_active falls the next cycle, no sw_evt pulse, SWITCH entered.
REQ-037 alarm_hit and sw_out[1] rise in the same RUN cycle -> ALARM entered, all sw_evt = 0.
REQ-038 rst low during SWITCH -> mode = 0 and data_char = data_mode0 immediately, no clock required.
